// File: rtl/branch_amend_pkg.sv
// Shared constants and lane-slice helpers for the
// multi-lane branch amend stage.
package branch_amend_pkg;

  localparam int NEED_REPAIR  = 0;
  localparam int REPAIR_W_DEF = 4;
  localparam int CKPT_W_DEF   = 8;

  function automatic int lane_lo(input int lane,
                                 input int w);
    return lane * w;
  endfunction

endpackage

// File: rtl/bra_oldest_sel.sv
// Picks the oldest (lowest index) requesting lane:
// one-hot, encoded index and any-request flag.
module bra_oldest_sel #(
  parameter int N  = 2,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  output logic [N-1:0]  onehot,
  output logic [SW-1:0] idx,
  output logic          any
);

  logic found;

  // first requester wins
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i] && !found) begin
        onehot[i] = 1'b1;
        idx       = SW'(i);
        found     = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/multi_lane_branch_amend.sv
// PREMEM stage register for an N-lane bundle: picks the
// oldest mispredicted branch and redirects once per bundle.
module multi_lane_branch_amend
  import branch_amend_pkg::*;
#(
  parameter int N_LANE   = 2,
  parameter int ADDR_W   = 32,
  parameter int GPR_W    = 5,
  parameter int CKPT_W   = CKPT_W_DEF,
  parameter int REPAIR_W = REPAIR_W_DEF,
  parameter int DS_KEEP  = 1,
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exc_occur_i,
  input  logic                       exc_mem_seg_i,
  input  logic                       mem_has_risk_i,
  input  logic                       in_valid_i,
  input  logic [N_LANE-1:0]          in_lane_vld_i,
  input  logic [N_LANE*GPR_W-1:0]    in_write_num_i,
  input  logic [N_LANE*ADDR_W-1:0]   in_vaddr_i,
  input  logic [N_LANE*ADDR_W-1:0]   in_alu_res_i,
  input  logic [N_LANE*ADDR_W-1:0]   in_corr_dest_i,
  input  logic [N_LANE-1:0]          in_corr_take_i,
  input  logic [N_LANE*REPAIR_W-1:0] in_repair_i,
  input  logic [N_LANE*CKPT_W-1:0]   in_ckpt_i,
  input  logic                       premem_allowin_i,
  output logic                       ok_to_change_o,
  output logic                       out_valid_o,
  output logic [N_LANE-1:0]          out_lane_vld_o,
  output logic [N_LANE*GPR_W-1:0]    out_write_num_o,
  output logic [N_LANE*ADDR_W-1:0]   out_vaddr_o,
  output logic [N_LANE*ADDR_W-1:0]   out_alu_res_o,
  output logic                       flush_o,
  output logic [ADDR_W-1:0]          err_vaddr_o,
  output logic [ADDR_W-1:0]          corr_dest_o,
  output logic                       corr_take_o,
  output logic [REPAIR_W-1:0]        repair_o,
  output logic [CKPT_W-1:0]          ckpt_o,
  output logic [CNT_W-1:0]           mispred_cnt_o
);

  localparam int SW = (N_LANE > 1) ? $clog2(N_LANE) : 1;

  logic                       has_data_q;
  logic                       had_flush_q;
  logic [N_LANE-1:0]          lane_vld_q;
  logic [N_LANE*GPR_W-1:0]    wnum_q;
  logic [N_LANE*ADDR_W-1:0]   vaddr_q;
  logic [N_LANE*ADDR_W-1:0]   alu_q;
  logic [N_LANE*ADDR_W-1:0]   dest_q;
  logic [N_LANE-1:0]          take_q;
  logic [N_LANE*REPAIR_W-1:0] repair_q;
  logic [N_LANE*CKPT_W-1:0]   ckpt_q;
  logic [CNT_W-1:0]           cnt_q;

  logic [N_LANE-1:0] rep;
  logic [N_LANE-1:0] sel_oh;
  logic [SW-1:0]     sel_idx;
  logic              any_rep;
  logic              exc;
  logic              ready;
  logic              load;
  logic              clr;

  for (genvar g = 0; g < N_LANE; g++) begin : g_rep
    assign rep[g] = lane_vld_q[g]
      & repair_q[lane_lo(g, REPAIR_W) + NEED_REPAIR];
  end

  bra_oldest_sel #(
    .N  (N_LANE),
    .SW (SW)
  ) u_sel (
    .req    (rep),
    .onehot (sel_oh),
    .idx    (sel_idx),
    .any    (any_rep)
  );

  assign exc   = exc_occur_i & exc_mem_seg_i;
  assign ready = !(mem_has_risk_i & any_rep);

  assign ok_to_change_o = !has_data_q | ready;
  assign flush_o = has_data_q & any_rep
    & !mem_has_risk_i & !had_flush_q & !exc;
  assign out_valid_o = has_data_q & ready
    & premem_allowin_i & !exc;

  assign load = premem_allowin_i & in_valid_i
    & !flush_o & !exc;
  assign clr = exc | (premem_allowin_i
    & !(in_valid_i & !flush_o));

  assign out_write_num_o = wnum_q;
  assign out_vaddr_o     = vaddr_q;
  assign out_alu_res_o   = alu_q;
  assign mispred_cnt_o   = cnt_q;

  // one-hot AND-OR mux of the selected branch
  always_comb begin
    err_vaddr_o = '0;
    corr_dest_o = '0;
    corr_take_o = 1'b0;
    repair_o    = '0;
    ckpt_o      = '0;
    for (int i = 0; i < N_LANE; i++) begin
      if (sel_oh[i]) begin
        err_vaddr_o |= vaddr_q[i*ADDR_W +: ADDR_W];
        corr_dest_o |= dest_q[i*ADDR_W +: ADDR_W];
        corr_take_o |= take_q[i];
        repair_o |= repair_q[i*REPAIR_W +: REPAIR_W];
        ckpt_o |= ckpt_q[i*CKPT_W +: CKPT_W];
      end
    end
  end

  // lanes younger than branch (+ delay slot) die
  always_comb begin
    out_lane_vld_o = '0;
    for (int i = 0; i < N_LANE; i++) begin
      out_lane_vld_o[i] = lane_vld_q[i]
        & has_data_q & ready
        & (!any_rep
           || i <= int'(sel_idx) + DS_KEEP);
    end
  end

  // stage register and flush-once flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      has_data_q  <= 1'b0;
      had_flush_q <= 1'b0;
      lane_vld_q  <= '0;
      wnum_q      <= '0;
      vaddr_q     <= '0;
      alu_q       <= '0;
      dest_q      <= '0;
      take_q      <= '0;
      repair_q    <= '0;
      ckpt_q      <= '0;
    end else if (clr) begin
      has_data_q  <= 1'b0;
      had_flush_q <= 1'b0;
      lane_vld_q  <= '0;
    end else if (load) begin
      has_data_q  <= 1'b1;
      had_flush_q <= 1'b0;
      lane_vld_q  <= in_lane_vld_i;
      wnum_q      <= in_write_num_i;
      vaddr_q     <= in_vaddr_i;
      alu_q       <= in_alu_res_i;
      dest_q      <= in_corr_dest_i;
      take_q      <= in_corr_take_i;
      repair_q    <= in_repair_i;
      ckpt_q      <= in_ckpt_i;
    end else if (flush_o) begin
      had_flush_q <= 1'b1;
    end
  end

  // saturating redirect counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (flush_o && cnt_q != '1) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multi_lane_branch_amend.sv
// Randomized bench with a bundle-level reference model
// for the multi-lane branch amend stage.
module tb_multi_lane_branch_amend;
  import branch_amend_pkg::*;

  localparam int N    = 4;
  localparam int AW   = 32;
  localparam int GW   = 5;
  localparam int CW   = 8;
  localparam int RW   = 4;
  localparam int CNTW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            exc_occur_i = 0;
  logic            exc_mem_seg_i = 0;
  logic            mem_has_risk_i = 0;
  logic            in_valid_i = 0;
  logic [N-1:0]    in_lane_vld_i = '0;
  logic [N*GW-1:0] in_write_num_i = '0;
  logic [N*AW-1:0] in_vaddr_i = '0;
  logic [N*AW-1:0] in_alu_res_i = '0;
  logic [N*AW-1:0] in_corr_dest_i = '0;
  logic [N-1:0]    in_corr_take_i = '0;
  logic [N*RW-1:0] in_repair_i = '0;
  logic [N*CW-1:0] in_ckpt_i = '0;
  logic            premem_allowin_i = 0;

  logic            ok_to_change_o;
  logic            out_valid_o;
  logic [N-1:0]    out_lane_vld_o;
  logic [N*GW-1:0] out_write_num_o;
  logic [N*AW-1:0] out_vaddr_o;
  logic [N*AW-1:0] out_alu_res_o;
  logic            flush_o;
  logic [AW-1:0]   err_vaddr_o;
  logic [AW-1:0]   corr_dest_o;
  logic            corr_take_o;
  logic [RW-1:0]   repair_o;
  logic [CW-1:0]   ckpt_o;
  logic [CNTW-1:0] mispred_cnt_o;

  multi_lane_branch_amend #(
    .N_LANE(N), .ADDR_W(AW), .GPR_W(GW),
    .CKPT_W(CW), .REPAIR_W(RW), .DS_KEEP(1),
    .CNT_W(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .exc_occur_i(exc_occur_i),
    .exc_mem_seg_i(exc_mem_seg_i),
    .mem_has_risk_i(mem_has_risk_i),
    .in_valid_i(in_valid_i),
    .in_lane_vld_i(in_lane_vld_i),
    .in_write_num_i(in_write_num_i),
    .in_vaddr_i(in_vaddr_i),
    .in_alu_res_i(in_alu_res_i),
    .in_corr_dest_i(in_corr_dest_i),
    .in_corr_take_i(in_corr_take_i),
    .in_repair_i(in_repair_i),
    .in_ckpt_i(in_ckpt_i),
    .premem_allowin_i(premem_allowin_i),
    .ok_to_change_o(ok_to_change_o),
    .out_valid_o(out_valid_o),
    .out_lane_vld_o(out_lane_vld_o),
    .out_write_num_o(out_write_num_o),
    .out_vaddr_o(out_vaddr_o),
    .out_alu_res_o(out_alu_res_o),
    .flush_o(flush_o),
    .err_vaddr_o(err_vaddr_o),
    .corr_dest_o(corr_dest_o),
    .corr_take_o(corr_take_o),
    .repair_o(repair_o),
    .ckpt_o(ckpt_o),
    .mispred_cnt_o(mispred_cnt_o)
  );

  // model: the bundle currently held
  bit            m_has, m_hf;
  bit [N-1:0]    m_vld;
  logic [N*GW-1:0] m_wn;
  logic [N*AW-1:0] m_va, m_alu, m_dest;
  logic [N-1:0]  m_take;
  logic [N*RW-1:0] m_rep;
  logic [N*CW-1:0] m_ck;
  int            m_cnt;
  bit            e_flush, e_exc;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_has = 0; m_hf = 0; m_vld = '0;
    m_wn = '0; m_va = '0; m_alu = '0;
    m_dest = '0; m_take = '0; m_rep = '0;
    m_ck = '0; m_cnt = 0;
  endtask

  task automatic model_check();
    int sel;
    bit anyr, rdy, ov;
    logic [N-1:0] lv;
    logic [AW-1:0] ev, ed;
    logic et;
    logic [RW-1:0] er;
    logic [CW-1:0] ec;
    sel = -1;
    for (int i = 0; i < N; i++)
      if (sel < 0 && m_vld[i]
          && m_rep[i*RW + NEED_REPAIR])
        sel = i;
    anyr = (sel >= 0);
    e_exc = exc_occur_i && exc_mem_seg_i;
    rdy = !(mem_has_risk_i && anyr);
    e_flush = m_has && anyr && !mem_has_risk_i
      && !m_hf && !e_exc;
    ov = m_has && rdy && premem_allowin_i && !e_exc;
    for (int i = 0; i < N; i++)
      lv[i] = m_has && rdy && m_vld[i]
        && (!anyr || i <= sel + 1);
    ev = '0; ed = '0; et = 0; er = '0; ec = '0;
    if (anyr) begin
      ev = m_va[sel*AW +: AW];
      ed = m_dest[sel*AW +: AW];
      et = m_take[sel];
      er = m_rep[sel*RW +: RW];
      ec = m_ck[sel*CW +: CW];
    end
    chk("ok_to_change", ok_to_change_o,
        !m_has || rdy);
    chk("out_valid", out_valid_o, ov);
    chk("out_lane_vld", out_lane_vld_o, lv);
    chk("flush", flush_o, e_flush);
    chk("err_vaddr", err_vaddr_o, ev);
    chk("corr_dest", corr_dest_o, ed);
    chk("corr_take", corr_take_o, et);
    chk("repair", repair_o, er);
    chk("ckpt", ckpt_o, ec);
    chk("mispred_cnt", mispred_cnt_o, m_cnt);
    chk("write_num", out_write_num_o, m_wn);
    chk("vaddr", out_vaddr_o, m_va);
    chk("alu_res", out_alu_res_o, m_alu);
  endtask

  task automatic model_update();
    bit ld, clr;
    ld = premem_allowin_i && in_valid_i
      && !e_flush && !e_exc;
    clr = e_exc || (premem_allowin_i
      && !(in_valid_i && !e_flush));
    if (e_flush && m_cnt < (1 << CNTW) - 1)
      m_cnt++;
    if (clr) begin
      m_has = 0; m_hf = 0; m_vld = '0;
    end else if (ld) begin
      m_has = 1; m_hf = 0;
      m_vld = in_lane_vld_i;
      m_wn = in_write_num_i;
      m_va = in_vaddr_i;
      m_alu = in_alu_res_i;
      m_dest = in_corr_dest_i;
      m_take = in_corr_take_i;
      m_rep = in_repair_i;
      m_ck = in_ckpt_i;
    end else if (e_flush) begin
      m_hf = 1;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_bundle(input logic [N-1:0] vld,
                            input logic [N-1:0] need,
                            input logic [AW-1:0] base);
    logic [RW-1:0] r;
    in_lane_vld_i = vld;
    for (int i = 0; i < N; i++) begin
      r = RW'($urandom);
      r[NEED_REPAIR] = need[i];
      in_repair_i[i*RW +: RW] = r;
      in_vaddr_i[i*AW +: AW] = base + AW'(4 * i);
      in_corr_dest_i[i*AW +: AW] =
        base + AW'(32'h40 + 4 * i);
      in_alu_res_i[i*AW +: AW] = $urandom;
      in_write_num_i[i*GW +: GW] = GW'($urandom);
      in_ckpt_i[i*CW +: CW] = CW'($urandom);
      in_corr_take_i[i] = 1'($urandom);
    end
  endtask

  task automatic idle_ctl();
    exc_occur_i = 0; exc_mem_seg_i = 0;
    mem_has_risk_i = 0;
  endtask

  initial begin
    logic [N-1:0] rv, rn;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ok_to_change", ok_to_change_o, 1'b1);
    chk("rst_cnt", mispred_cnt_o, 0);
    chk("rst_out_valid", out_valid_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // lane0 mispredicts, lane1 plain, held 3 cycles
    set_bundle(4'b0011, 4'b0001, 32'h1000_0000);
    premem_allowin_i = 1; in_valid_i = 1;
    cycle();
    premem_allowin_i = 0; in_valid_i = 0;
    #1;
    chk("t1_flush", flush_o, 1'b1);
    chk("t1_corr_dest", corr_dest_o, 32'h1000_0040);
    chk("t1_err_vaddr", err_vaddr_o, 32'h1000_0000);
    chk("t1_lanes", out_lane_vld_o, 4'b0011);
    cycle();
    #1;
    chk("t1_cnt", mispred_cnt_o, 1);
    cycle();
    cycle();
    #1;
    chk("t1_cnt_held", mispred_cnt_o, 1);
    chk("t1_no_reflush", flush_o, 1'b0);

    // hazard holds off the redirect
    premem_allowin_i = 1;
    cycle();
    set_bundle(4'b1111, 4'b0110, 32'h2000_0000);
    in_valid_i = 1;
    cycle();
    premem_allowin_i = 0; in_valid_i = 0;
    mem_has_risk_i = 1;
    #1;
    chk("t2_ok_to_change", ok_to_change_o, 1'b0);
    chk("t2_flush_blocked", flush_o, 1'b0);
    cycle();
    cycle();
    mem_has_risk_i = 0;
    #1;
    chk("t2_flush", flush_o, 1'b1);
    chk("t2_err_vaddr", err_vaddr_o, 32'h2000_0004);
    chk("t2_lanes", out_lane_vld_o, 4'b0111);
    cycle();
    premem_allowin_i = 1;
    cycle();
    #1;
    chk("t2_cnt", mispred_cnt_o, 2);

    // exception beats a pending redirect
    set_bundle(4'b0001, 4'b0001, 32'h3000_0000);
    in_valid_i = 1;
    cycle();
    exc_occur_i = 1; exc_mem_seg_i = 1;
    #1;
    chk("t3_flush", flush_o, 1'b0);
    chk("t3_out_valid", out_valid_o, 1'b0);
    cycle();
    idle_ctl();
    premem_allowin_i = 0; in_valid_i = 0;
    #1;
    chk("t3_cleared", out_lane_vld_o, 4'b0000);
    chk("t3_ok", ok_to_change_o, 1'b1);
    cycle();
    #1;
    chk("t3_cnt", mispred_cnt_o, 2);

    // counter saturation
    for (int k = 0; k < 16; k++) begin
      set_bundle(4'b0001, 4'b0001, $urandom);
      premem_allowin_i = 1; in_valid_i = 1;
      cycle();
      in_valid_i = 0;
      cycle();
    end
    #1;
    chk("t4_cnt_sat", mispred_cnt_o, 4'hF);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      exc_occur_i = ($urandom % 8 == 0);
      exc_mem_seg_i = 1'($urandom);
      mem_has_risk_i = ($urandom % 5 == 0);
      premem_allowin_i = ($urandom % 4 != 0);
      in_valid_i = ($urandom % 4 != 0);
      for (int i = 0; i < N; i++) begin
        rv[i] = 1'($urandom);
        rn[i] = ($urandom % 10 < 3);
      end
      set_bundle(rv, rn, $urandom);
      cycle();
    end

    // async reset in the middle of a bundle
    idle_ctl();
    set_bundle(4'b1111, 4'b0001, 32'h4000_0000);
    premem_allowin_i = 1; in_valid_i = 1;
    cycle();
    premem_allowin_i = 0; in_valid_i = 0;
    #2;
    rst = 1'b0;
    #1;
    chk("t5_flush", flush_o, 1'b0);
    chk("t5_lanes", out_lane_vld_o, 4'b0000);
    chk("t5_cnt", mispred_cnt_o, 0);
    chk("t5_dest", corr_dest_o, 0);
    chk("t5_vaddr", out_vaddr_o, 0);
    chk("t5_ok", ok_to_change_o, 1'b1);
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) cycle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
